core_pipe_dispatch: RTL and testbench

//  Decode-to-execute pipeline register. Captures the decoded bundle from decode (s1_*) and presents it to the execute stage (s2_*).

---
 rtl/core_pipe_dispatch.sv | 140 ++++++++++++++
 tb/tb_core_pipe_dispatch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_pipe_dispatch.sv
// ============================================================================
// Module   : core_pipe_dispatch
// Purpose  : Decode-to-execute pipeline register with RAW hazard stall and
//            control-flow flush. Optional macro CORE_DISPATCH_FWD_EN enables
//            writeback-to-dispatch operand forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_pipe_dispatch #(
    parameter int XL         = 31,
    parameter int REG_ADDR_R = 4,
    parameter int ALU_OP_R   = 5,
    parameter int LSU_OP_R   = 7,
    parameter int MDU_OP_R   = 3,
    parameter int CSR_OP_R   = 2,
    parameter int CFU_OP_R   = 2
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [XL:0]           s1_pc,
    input  logic [XL:0]           s1_opr_a,
    input  logic [XL:0]           s1_opr_b,
    input  logic [XL:0]           s1_opr_c,
    input  logic [REG_ADDR_R:0]   s1_rs1,
    input  logic [REG_ADDR_R:0]   s1_rs2,
    input  logic                  s1_rs1_en,
    input  logic                  s1_rs2_en,
    input  logic                  s1_fwd_a,
    input  logic                  s1_fwd_b,
    input  logic                  s1_fwd_c,
    input  logic [REG_ADDR_R:0]   s1_rd,
    input  logic                  s1_rd_en,
    input  logic [ALU_OP_R:0]     s1_alu_op,
    input  logic [LSU_OP_R:0]     s1_lsu_op,
    input  logic [MDU_OP_R:0]     s1_mdu_op,
    input  logic [CSR_OP_R:0]     s1_csr_op,
    input  logic [CFU_OP_R:0]     s1_cfu_op,
    input  logic                  s1_op_w,
    input  logic [31:0]           s1_instr,
    output logic                  s2_valid,
    input  logic                  s2_ready,
    output logic [XL:0]           s2_pc,
    output logic [XL:0]           s2_opr_a,
    output logic [XL:0]           s2_opr_b,
    output logic [XL:0]           s2_opr_c,
    output logic [REG_ADDR_R:0]   s2_rd,
    output logic                  s2_rd_en,
    output logic [ALU_OP_R:0]     s2_alu_op,
    output logic [LSU_OP_R:0]     s2_lsu_op,
    output logic [MDU_OP_R:0]     s2_mdu_op,
    output logic [CSR_OP_R:0]     s2_csr_op,
    output logic [CFU_OP_R:0]     s2_cfu_op,
    output logic                  s2_op_w,
    output logic [31:0]           s2_instr,
    input  logic                  wb_wen,
    input  logic [REG_ADDR_R:0]   wb_addr,
    input  logic [XL:0]           wb_wdata,
    input  logic                  cf_flush
);

    localparam int c_BUNDLE_W = 4 * (XL + 1) + (REG_ADDR_R + 1) + 1
                              + (ALU_OP_R + 1) + (LSU_OP_R + 1) + (MDU_OP_R + 1)
                              + (CSR_OP_R + 1) + (CFU_OP_R + 1) + 1 + 32;

    logic                  s2_valid_q, s2_valid_d;
    logic                  wb_pend_q, wb_pend_d;
    logic [c_BUNDLE_W-1:0] bundle_q, bundle_d;

    logic        load_en;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        raw_hazard;
    logic        wb_match;
    logic        fwd_hit;
    logic        hazard;
    logic        capture;
    logic [XL:0] opr_a_in;
    logic [XL:0] opr_b_in;
    logic [XL:0] opr_c_in;

    assign {s2_pc, s2_opr_a, s2_opr_b, s2_opr_c, s2_rd, s2_rd_en, s2_alu_op,
            s2_lsu_op, s2_mdu_op, s2_csr_op, s2_cfu_op, s2_op_w, s2_instr} = bundle_q;
    assign s2_valid = s2_valid_q;

    assign load_en    = !s2_valid_q || s2_ready;
    assign rs1_hit    = s1_rs1_en && (s1_rs1 == s2_rd);
    assign rs2_hit    = s1_rs2_en && (s1_rs2 == s2_rd);
    // wb_pend is only ever set for rd != x0, so x0 sources can never stall.
    assign raw_hazard = s1_valid && wb_pend_q && (rs1_hit || rs2_hit);
    assign wb_match   = wb_wen && (wb_addr == s2_rd);

`ifdef CORE_DISPATCH_FWD_EN
    assign fwd_hit = raw_hazard && wb_match;
`else
    assign fwd_hit = 1'b0;
`endif

    assign hazard   = raw_hazard && !fwd_hit;
    assign capture  = load_en && !cf_flush && s1_valid && !hazard;
    assign s1_ready = g_resetn && (cf_flush || (load_en && !hazard));

    assign opr_a_in = (fwd_hit && s1_fwd_a && rs1_hit) ? wb_wdata : s1_opr_a;
    assign opr_b_in = (fwd_hit && s1_fwd_b && rs2_hit) ? wb_wdata : s1_opr_b;
    assign opr_c_in = (fwd_hit && s1_fwd_c && rs2_hit) ? wb_wdata : s1_opr_c;

    always_comb begin
        s2_valid_d = s2_valid_q;
        wb_pend_d  = wb_pend_q;
        bundle_d   = bundle_q;
        if (load_en) begin
            // Slot either reloads or empties; the pending write tracks the new occupant.
            s2_valid_d = capture;
            wb_pend_d  = capture && s1_rd_en && (s1_rd != '0);
        end else if (wb_match) begin
            wb_pend_d = 1'b0;
        end
        if (capture) begin
            bundle_d = {s1_pc, opr_a_in, opr_b_in, opr_c_in, s1_rd, s1_rd_en, s1_alu_op,
                        s1_lsu_op, s1_mdu_op, s1_csr_op, s1_cfu_op, s1_op_w, s1_instr};
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            s2_valid_q <= 1'b0;
            wb_pend_q  <= 1'b0;
            bundle_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            wb_pend_q  <= wb_pend_d;
            bundle_q   <= bundle_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_pipe_dispatch.sv
// ============================================================================
// Module   : tb_core_pipe_dispatch
// Purpose  : Self-checking bench for core_pipe_dispatch (table vectors, directed
//            corner sequences, randomized run against a slot-level model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_pipe_dispatch;

`ifdef CORE_DISPATCH_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [4:0]  rd;
        logic        rd_en;
        logic [5:0]  alu;
        logic [7:0]  lsu;
        logic [3:0]  mdu;
        logic [2:0]  csr;
        logic [2:0]  cfu;
        logic        op_w;
        logic [31:0] instr;
    } bundle_t;

    typedef struct {
        logic [4:0] rd;   bit rd_en;
        logic [4:0] rs1;  bit rs1_en;
        logic [4:0] rs2;  bit rs2_en;
        bit rdy; bit flush; bit exp_ready;
    } vec_t;

    logic g_clk, g_resetn;
    logic s1_valid, s1_ready, s2_valid, s2_ready, cf_flush;
    logic [4:0] s1_rs1, s1_rs2, wb_addr;
    logic s1_rs1_en, s1_rs2_en, s1_fwd_a, s1_fwd_b, s1_fwd_c, wb_wen;
    logic [31:0] wb_wdata;
    bundle_t in_b, dut_b;

    logic [31:0] s2_pc, s2_opr_a, s2_opr_b, s2_opr_c, s2_instr;
    logic [4:0]  s2_rd;
    logic        s2_rd_en, s2_op_w;
    logic [5:0]  s2_alu_op;
    logic [7:0]  s2_lsu_op;
    logic [3:0]  s2_mdu_op;
    logic [2:0]  s2_csr_op, s2_cfu_op;

    assign dut_b = {s2_pc, s2_opr_a, s2_opr_b, s2_opr_c, s2_rd, s2_rd_en, s2_alu_op,
                    s2_lsu_op, s2_mdu_op, s2_csr_op, s2_cfu_op, s2_op_w, s2_instr};

    core_pipe_dispatch dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .s1_valid(s1_valid), .s1_ready(s1_ready),
        .s1_pc(in_b.pc), .s1_opr_a(in_b.a), .s1_opr_b(in_b.b), .s1_opr_c(in_b.c),
        .s1_rs1(s1_rs1), .s1_rs2(s1_rs2), .s1_rs1_en(s1_rs1_en), .s1_rs2_en(s1_rs2_en),
        .s1_fwd_a(s1_fwd_a), .s1_fwd_b(s1_fwd_b), .s1_fwd_c(s1_fwd_c),
        .s1_rd(in_b.rd), .s1_rd_en(in_b.rd_en),
        .s1_alu_op(in_b.alu), .s1_lsu_op(in_b.lsu), .s1_mdu_op(in_b.mdu),
        .s1_csr_op(in_b.csr), .s1_cfu_op(in_b.cfu), .s1_op_w(in_b.op_w), .s1_instr(in_b.instr),
        .s2_valid(s2_valid), .s2_ready(s2_ready),
        .s2_pc(s2_pc), .s2_opr_a(s2_opr_a), .s2_opr_b(s2_opr_b), .s2_opr_c(s2_opr_c),
        .s2_rd(s2_rd), .s2_rd_en(s2_rd_en), .s2_alu_op(s2_alu_op), .s2_lsu_op(s2_lsu_op),
        .s2_mdu_op(s2_mdu_op), .s2_csr_op(s2_csr_op), .s2_cfu_op(s2_cfu_op),
        .s2_op_w(s2_op_w), .s2_instr(s2_instr),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .cf_flush(cf_flush)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the execute slot: what it holds and whether its GPR write is still owed.
    bit      m_valid;
    bit      m_owed;
    bundle_t m_b;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle();
        s1_valid = 0; s2_ready = 1; cf_flush = 0; wb_wen = 0; wb_addr = 0; wb_wdata = 0;
        s1_rs1 = 0; s1_rs2 = 0; s1_rs1_en = 0; s1_rs2_en = 0;
        s1_fwd_a = 0; s1_fwd_b = 0; s1_fwd_c = 0; in_b = '0;
    endtask

    task automatic do_reset();
        idle();
        g_resetn = 0;
        #1;
        chk("reset_s1_ready", s1_ready, 0);
        repeat (2) tick();
        chk("reset_s2_valid", s2_valid, 0);
        chk("reset_s2_data", dut_b, 0);
        g_resetn = 1;
        m_valid = 0; m_owed = 0; m_b = '0;
    endtask

    // Leaves an instruction with the given rd resident in execute.
    task automatic preload(input logic [4:0] rd, input bit rd_en, input logic [31:0] pc);
        idle();
        tick();
        s1_valid = 1; in_b.pc = pc; in_b.rd = rd; in_b.rd_en = rd_en;
        tick();
        idle();
    endtask

    // Model: decode may go when flushed, or when the slot frees and no owed source is read
    // (unless that owed value is being written right now and forwarding is built in).
    task automatic model_eval(output bit rdy, output bit stall, output bit fwd);
        bit reads_owed;
        bit slot_free;
        reads_owed = m_owed && ((s1_rs1_en && s1_rs1 == m_b.rd) || (s1_rs2_en && s1_rs2 == m_b.rd));
        fwd   = FWD && s1_valid && reads_owed && wb_wen && wb_addr == m_b.rd;
        stall = s1_valid && reads_owed && !fwd;
        slot_free = !m_valid || s2_ready;
        rdy = cf_flush || (slot_free && !stall);
    endtask

    task automatic model_advance();
        bit rdy, stall, fwd;
        bundle_t nb;
        model_eval(rdy, stall, fwd);
        if (!m_valid || s2_ready) begin
            if (s1_valid && rdy && !cf_flush) begin
                nb = in_b;
                if (fwd && s1_fwd_a && s1_rs1_en && s1_rs1 == m_b.rd) nb.a = wb_wdata;
                if (fwd && s1_fwd_b && s1_rs2_en && s1_rs2 == m_b.rd) nb.b = wb_wdata;
                if (fwd && s1_fwd_c && s1_rs2_en && s1_rs2 == m_b.rd) nb.c = wb_wdata;
                m_b = nb;
                m_valid = 1;
                m_owed = nb.rd_en && nb.rd != 0;
            end else begin
                m_valid = 0;
                m_owed = 0;
            end
        end else if (wb_wen && wb_addr == m_b.rd) begin
            m_owed = 0;
        end
    endtask

    vec_t vecs[9];

    initial begin
        bit rdy, stall, fwd;

        vecs[0] = '{5'd5, 1, 5'd5, 1, 5'd0, 0, 1, 0, 0};
        vecs[1] = '{5'd5, 1, 5'd5, 0, 5'd0, 0, 1, 0, 1};
        vecs[2] = '{5'd5, 1, 5'd1, 1, 5'd5, 1, 1, 0, 0};
        vecs[3] = '{5'd0, 1, 5'd0, 1, 5'd0, 1, 1, 0, 1};
        vecs[4] = '{5'd5, 0, 5'd5, 1, 5'd5, 1, 1, 0, 1};
        vecs[5] = '{5'd5, 1, 5'd5, 1, 5'd0, 0, 0, 0, 0};
        vecs[6] = '{5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 0, 0};
        vecs[7] = '{5'd5, 1, 5'd6, 1, 5'd7, 1, 1, 0, 1};
        vecs[8] = '{5'd5, 1, 5'd5, 1, 5'd5, 1, 0, 1, 1};

        do_reset();

        // Simple issue into an empty slot.
        s1_valid = 1; in_b.pc = 32'h100; s2_ready = 1;
        #1;
        chk("t1_s1_ready", s1_ready, 1);
        tick();
        chk("t1_s2_valid", s2_valid, 1);
        chk("t1_s2_pc", s2_pc, 32'h100);

        foreach (vecs[i]) begin
            preload(vecs[i].rd, vecs[i].rd_en, 32'h1000 + i);
            s1_valid = 1;
            s1_rs1 = vecs[i].rs1; s1_rs1_en = vecs[i].rs1_en;
            s1_rs2 = vecs[i].rs2; s1_rs2_en = vecs[i].rs2_en;
            s2_ready = vecs[i].rdy; cf_flush = vecs[i].flush;
            #1;
            chk($sformatf("vec%0d_s1_ready", i), s1_ready, vecs[i].exp_ready);
        end

        // Load-use stall resolved by writeback of x5.
        preload(5'd5, 1, 32'h180);
        s1_valid = 1; in_b.pc = 32'h200; in_b.a = 32'h1111;
        s1_rs1 = 5; s1_rs1_en = 1; s1_fwd_a = 1; s2_ready = 0;
        #1;
        chk("t2_stall_ready", s1_ready, 0);
        tick();
        chk("t2_stall_pc", s2_pc, 32'h180);
        s2_ready = 1; wb_wen = 1; wb_addr = 5; wb_wdata = 32'hDEAD;
        #1;
        chk("t2_wb_ready", s1_ready, FWD);
        tick();
        wb_wen = 0;
        if (FWD) begin
            chk("t2_fwd_valid", s2_valid, 1);
            chk("t2_fwd_pc", s2_pc, 32'h200);
            chk("t2_fwd_opr_a", s2_opr_a, 32'hDEAD);
        end else begin
            chk("t2_bubble_valid", s2_valid, 0);
            #1;
            chk("t2_late_ready", s1_ready, 1);
            tick();
            chk("t2_late_pc", s2_pc, 32'h200);
            chk("t2_late_opr_a", s2_opr_a, 32'h1111);
        end

        // Flush while execute retires: slot empties, decode bundle dropped.
        preload(5'd1, 0, 32'h600);
        s1_valid = 1; in_b.pc = 32'h700; s2_ready = 1; cf_flush = 1;
        #1;
        chk("t4_s1_ready", s1_ready, 1);
        tick();
        chk("t4_s2_valid", s2_valid, 0);

        // Flush while execute is busy: held bundle untouched.
        preload(5'd1, 0, 32'h300);
        s1_valid = 1; in_b.pc = 32'h400; s2_ready = 0; cf_flush = 1;
        #1;
        chk("t5_s1_ready", s1_ready, 1);
        tick();
        chk("t5_s2_valid", s2_valid, 1);
        chk("t5_s2_pc", s2_pc, 32'h300);

        // Backpressure for three cycles, then asynchronous reset mid-stall.
        preload(5'd1, 0, 32'h500);
        s1_valid = 1; in_b.pc = 32'h510; s2_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t6_ready_%0d", k), s1_ready, 0);
            tick();
            chk($sformatf("t6_pc_%0d", k), s2_pc, 32'h500);
            chk($sformatf("t6_valid_%0d", k), s2_valid, 1);
        end
        #2;
        g_resetn = 0;
        #1;
        chk("t6_async_valid", s2_valid, 0);
        chk("t6_async_ready", s1_ready, 0);
        chk("t6_async_pc", s2_pc, 0);

        do_reset();

        for (int n = 0; n < 400; n++) begin
            s1_valid  = ($urandom_range(3, 0) != 0);
            s2_ready  = ($urandom_range(1, 0) != 0);
            cf_flush  = ($urandom_range(7, 0) == 0);
            wb_wen    = ($urandom_range(1, 0) != 0);
            wb_addr   = ($urandom_range(1, 0) != 0) ? m_b.rd : 5'($urandom_range(3, 0));
            wb_wdata  = $urandom;
            s1_rs1    = 5'($urandom_range(3, 0));
            s1_rs2    = 5'($urandom_range(3, 0));
            s1_rs1_en = ($urandom_range(1, 0) != 0);
            s1_rs2_en = ($urandom_range(1, 0) != 0);
            s1_fwd_a  = ($urandom_range(1, 0) != 0);
            s1_fwd_b  = ($urandom_range(1, 0) != 0);
            s1_fwd_c  = ($urandom_range(1, 0) != 0);
            in_b.pc   = $urandom;
            in_b.a    = $urandom;
            in_b.b    = $urandom;
            in_b.c    = $urandom;
            in_b.rd   = 5'($urandom_range(3, 0));
            in_b.rd_en = ($urandom_range(1, 0) != 0);
            in_b.alu  = 6'($urandom);
            in_b.lsu  = 8'($urandom);
            in_b.mdu  = 4'($urandom);
            in_b.csr  = 3'($urandom);
            in_b.cfu  = 3'($urandom);
            in_b.op_w = ($urandom_range(1, 0) != 0);
            in_b.instr = $urandom;
            #1;
            model_eval(rdy, stall, fwd);
            chk("rnd_s1_ready", s1_ready, rdy);
            model_advance();
            tick();
            chk("rnd_s2_valid", s2_valid, m_valid);
            chk("rnd_s2_bundle", dut_b, m_b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
